// File: rtl/cdc_fifo_rd_packer_if.sv
// Stream bundle between the CDC FIFO read port, the word packer and the downstream beat consumer.
// The master modport is the packer's view; slave is the view of whoever drives the FIFO side and sinks beats.
interface cdc_fifo_rd_packer_if #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4,
    parameter int CW    = $clog2(RATIO + 1)
);
    logic [WIDTH-1:0]       fifo_data_out;
    logic                   fifo_empty;
    logic                   fifo_rd_en;
    logic [WIDTH*RATIO-1:0] out_data;
    logic [CW-1:0]          out_words;
    logic                   out_valid;
    logic                   out_ready;
    logic                   flush;
    logic                   flush_done;

    modport master (
        input  fifo_data_out, fifo_empty, out_ready, flush,
        output fifo_rd_en, out_data, out_words, out_valid, flush_done
    );

    modport slave (
        output fifo_data_out, fifo_empty, out_ready, flush,
        input  fifo_rd_en, out_data, out_words, out_valid, flush_done
    );
endinterface

// File: rtl/cdc_fifo_rd_packer.sv
// Read-domain consumer of the async CDC FIFO: packs RATIO popped words into one beat on a
// valid/ready stream, with a flush that emits a partially filled beat plus its word count.
module cdc_fifo_rd_packer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4,
    parameter int CW    = $clog2(RATIO + 1)
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst_n,
    cdc_fifo_rd_packer_if.master bus
);

    typedef enum logic [1:0] {FILL, DRAIN, EMIT, DONE} state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          pack_cnt_q, pack_cnt_d;
    logic                   inflight_q;
    logic [WIDTH-1:0]       lanes_q [RATIO];
    logic [WIDTH*RATIO-1:0] out_data_q, out_data_d;
    logic [CW-1:0]          out_words_q, out_words_d;
    logic                   out_valid_q, out_valid_d;
    logic                   flush_done_q, flush_done_d;

    logic [CW:0]            pending;
    logic                   out_free;
    logic                   rd_en;
    logic [WIDTH*RATIO-1:0] full_beat;
    logic [WIDTH*RATIO-1:0] masked_beat;

    assign pending  = {1'b0, pack_cnt_q} + {{CW{1'b0}}, inflight_q};
    assign out_free = !out_valid_q || bus.out_ready;

    // The special case lets the pop for the next beat overlap the landing of the last word
    // of the current one, giving one pop per cycle while downstream keeps accepting.
    assign rd_en = rd_rst_n && (state_q == FILL) && !bus.flush && !bus.fifo_empty &&
                   ((pending < (CW+1)'(RATIO)) ||
                    ((pending == (CW+1)'(RATIO)) && inflight_q &&
                     (pack_cnt_q == CW'(RATIO - 1)) && out_free));

    // full_beat bypasses the landing word straight into its lane; masked_beat zeroes unused lanes.
    always_comb begin
        full_beat   = '0;
        masked_beat = '0;
        for (int i = 0; i < RATIO; i++) begin
            full_beat[i*WIDTH +: WIDTH]   = (inflight_q && (pack_cnt_q == CW'(i))) ?
                                            bus.fifo_data_out : lanes_q[i];
            masked_beat[i*WIDTH +: WIDTH] = (CW'(i) < pack_cnt_q) ? lanes_q[i] : '0;
        end
    end

    // NOTE: every signal gets a default at the top so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        pack_cnt_d   = pack_cnt_q;
        out_data_d   = out_data_q;
        out_words_d  = out_words_q;
        out_valid_d  = out_valid_q && !bus.out_ready;
        flush_done_d = 1'b0;

        if (inflight_q) begin
            if ((pack_cnt_q == CW'(RATIO - 1)) && out_free) begin
                out_data_d  = full_beat;
                out_words_d = CW'(RATIO);
                out_valid_d = 1'b1;
                pack_cnt_d  = '0;
            end else begin
                pack_cnt_d = pack_cnt_q + CW'(1);
            end
        end else if ((state_q == FILL) && (pack_cnt_q == CW'(RATIO)) && out_free) begin
            out_data_d  = full_beat;
            out_words_d = CW'(RATIO);
            out_valid_d = 1'b1;
            pack_cnt_d  = '0;
        end

        case (state_q)
            FILL: begin
                if (bus.flush) state_d = DRAIN;
            end
            DRAIN: begin
                // Decide only once the last issued word has landed in the pack register.
                if (!inflight_q) begin
                    if (pack_cnt_q == '0) begin
                        state_d      = DONE;
                        flush_done_d = 1'b1;
                    end else begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_free) begin
                    out_data_d   = masked_beat;
                    out_words_d  = pack_cnt_q;
                    out_valid_d  = 1'b1;
                    pack_cnt_d   = '0;
                    state_d      = DONE;
                    flush_done_d = 1'b1;
                end
            end
            DONE:    state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q      <= FILL;
            pack_cnt_q   <= '0;
            inflight_q   <= 1'b0;
            out_data_q   <= '0;
            out_words_q  <= '0;
            out_valid_q  <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pack_cnt_q   <= pack_cnt_d;
            inflight_q   <= rd_en;
            out_data_q   <= out_data_d;
            out_words_q  <= out_words_d;
            out_valid_q  <= out_valid_d;
            flush_done_q <= flush_done_d;
        end
    end

    // NOTE: the lanes are storage without reset; stale contents never escape because every
    // read of them is qualified by pack_cnt or overwritten by the landing word.
    always_ff @(posedge rd_clk) begin
        if (inflight_q) begin
            for (int i = 0; i < RATIO; i++) begin
                if (pack_cnt_q == CW'(i)) lanes_q[i] <= bus.fifo_data_out;
            end
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_data   = out_data_q;
    assign bus.out_words  = out_words_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.flush_done = flush_done_q;

endmodule

// File: tb/tb_cdc_fifo_rd_packer.sv
// Bench for cdc_fifo_rd_packer (WIDTH=8, RATIO=4): a queue-based FIFO model feeds the DUT,
// delivered beats are compared with beats formed by grouping the pushed words in order.
module tb_cdc_fifo_rd_packer;

    localparam int WIDTH = 8;
    localparam int RATIO = 4;
    localparam int CW    = $clog2(RATIO + 1);

    typedef struct packed {
        int          n;
        logic [7:0]  base;
        int          stall;
        bit          do_flush;
        bit          b2b;
        int          exp_beats;
        int          exp_stall_pops;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;
        int          w0;
        int          w1;
        int          w2;
    } vec_t;

    logic rd_clk;
    logic rd_rst_n;

    cdc_fifo_rd_packer_if #(.WIDTH(WIDTH), .RATIO(RATIO)) bus ();

    cdc_fifo_rd_packer #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
        .rd_clk  (rd_clk),
        .rd_rst_n(rd_rst_n),
        .bus     (bus)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  fifo_q [$];
    logic [31:0] obs_d [$];
    int          obs_w [$];
    int          pop_cnt, fd_cnt, cyc_cnt, first_pop, last_pop;
    bit          gate, toggle, hold_q;
    logic [31:0] hold_d;
    logic [CW-1:0] hold_w;
    vec_t        vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: sample at the falling edge, then update the FIFO model just after the rising edge.
    task automatic cyc();
        logic popped;
        @(negedge rd_clk);
        popped = bus.fifo_rd_en && !bus.fifo_empty;
        if (bus.fifo_empty) check("rd_en_while_empty", 64'(bus.fifo_rd_en), 64'd0);
        if (hold_q) begin
            check("held_valid", 64'(bus.out_valid), 64'd1);
            check("held_data", 64'(bus.out_data), 64'(hold_d));
            check("held_words", 64'(bus.out_words), 64'(hold_w));
        end
        hold_q = bus.out_valid && !bus.out_ready;
        hold_d = bus.out_data;
        hold_w = bus.out_words;
        if (bus.out_valid && bus.out_ready) begin
            obs_d.push_back(bus.out_data);
            obs_w.push_back(int'(bus.out_words));
        end
        if (bus.flush_done) fd_cnt++;
        @(posedge rd_clk);
        #1;
        cyc_cnt++;
        if (popped) begin
            bus.fifo_data_out = fifo_q.pop_front();
            pop_cnt++;
            if (first_pop < 0) first_pop = cyc_cnt;
            last_pop = cyc_cnt;
        end else begin
            bus.fifo_data_out = 8'($urandom);
        end
        if (toggle) gate = !gate;
        bus.fifo_empty = (fifo_q.size() == 0) || gate;
    endtask

    task automatic do_reset(input bit check_it);
        rd_rst_n          = 1'b0;
        bus.flush         = 1'b0;
        bus.out_ready     = 1'b0;
        bus.fifo_empty    = 1'b1;
        bus.fifo_data_out = '0;
        gate = 1'b0; toggle = 1'b0; hold_q = 1'b0;
        fifo_q.delete(); obs_d.delete(); obs_w.delete();
        pop_cnt = 0; fd_cnt = 0; cyc_cnt = 0; first_pop = -1; last_pop = -1;
        @(posedge rd_clk);
        #1;
        if (check_it) begin
            check("rst_out_valid", 64'(bus.out_valid), 64'd0);
            check("rst_out_data", 64'(bus.out_data), 64'd0);
            check("rst_out_words", 64'(bus.out_words), 64'd0);
            check("rst_flush_done", 64'(bus.flush_done), 64'd0);
            check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        end
        @(posedge rd_clk);
        #1;
        rd_rst_n = 1'b1;
    endtask

    task automatic push_words(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) fifo_q.push_back(8'(base + 8'(i)));
        bus.fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] exp_d [3];
        int          exp_w [3];
        int          first_valid, stall_pops, tail;
        bit          flushed;
        exp_d[0] = v.d0; exp_d[1] = v.d1; exp_d[2] = v.d2;
        exp_w[0] = v.w0; exp_w[1] = v.w1; exp_w[2] = v.w2;
        do_reset(1'b0);
        push_words(v.n, v.base);
        bus.out_ready = (v.stall == 0);
        first_valid = -1; stall_pops = -1; tail = -1; flushed = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!bus.out_ready && first_valid >= 0 && (cyc_cnt - first_valid) >= v.stall) begin
                bus.out_ready = 1'b1;
                stall_pops = pop_cnt;
            end
            bus.flush = v.do_flush && !flushed && (pop_cnt == v.n);
            if (bus.flush) flushed = 1'b1;
            cyc();
            bus.flush = 1'b0;
            if (first_valid < 0 && bus.out_valid) first_valid = cyc_cnt;
            if (tail < 0 && obs_d.size() >= v.exp_beats && (!v.do_flush || fd_cnt > 0)) tail = 6;
            if (tail == 0) break;
            if (tail > 0) tail--;
        end
        check($sformatf("v%0d_beats", idx), 64'(obs_d.size()), 64'(v.exp_beats));
        for (int b = 0; b < v.exp_beats && b < obs_d.size(); b++) begin
            check($sformatf("v%0d_beat%0d_data", idx, b), 64'(obs_d[b]), 64'(exp_d[b]));
            check($sformatf("v%0d_beat%0d_words", idx, b), 64'(obs_w[b]), 64'(exp_w[b]));
        end
        check($sformatf("v%0d_pops", idx), 64'(pop_cnt), 64'(v.n));
        check($sformatf("v%0d_flush_done", idx), 64'(fd_cnt), 64'(v.do_flush));
        if (v.b2b) check($sformatf("v%0d_pop_span", idx), 64'(last_pop - first_pop), 64'(v.n - 1));
        if (v.stall > 0) check($sformatf("v%0d_stall_pops", idx), 64'(stall_pops), 64'(v.exp_stall_pops));
    endtask

    initial begin
        vecs[0] = '{8,  8'h01, 0,  1'b0, 1'b1, 2, 0, 32'h04030201, 32'h08070605, 32'h0, 4, 4, 0};
        vecs[1] = '{12, 8'h01, 10, 1'b0, 1'b0, 3, 8, 32'h04030201, 32'h08070605, 32'h0c0b0a09, 4, 4, 4};
        vecs[2] = '{6,  8'h11, 0,  1'b1, 1'b1, 2, 0, 32'h14131211, 32'h00001615, 32'h0, 4, 2, 0};
        vecs[3] = '{3,  8'hA1, 0,  1'b1, 1'b1, 1, 0, 32'h00A3A2A1, 32'h0, 32'h0, 3, 0, 0};
        vecs[4] = '{4,  8'h21, 5,  1'b1, 1'b1, 1, 4, 32'h24232221, 32'h0, 32'h0, 4, 0, 0};
        vecs[5] = '{1,  8'h5A, 0,  1'b1, 1'b1, 1, 0, 32'h0000005A, 32'h0, 32'h0, 1, 0, 0};

        do_reset(1'b1);
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Flush while the third word is in flight, with more words waiting in the FIFO.
        do_reset(1'b0);
        push_words(7, 8'h31);
        bus.out_ready = 1'b1;
        repeat (3) cyc();
        check("fl_pops_before", 64'(pop_cnt), 64'd3);
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        for (int c = 0; c < 20 && fd_cnt == 0; c++) cyc();
        check("fl_done", 64'(fd_cnt), 64'd1);
        check("fl_no_pop", 64'(pop_cnt), 64'd3);
        check("fl_beats", 64'(obs_d.size()), 64'd1);
        if (obs_d.size() > 0) begin
            check("fl_part_data", 64'(obs_d[0]), 64'h00333231);
            check("fl_part_words", 64'(obs_w[0]), 64'd3);
        end
        for (int c = 0; c < 30 && obs_d.size() < 2; c++) cyc();
        check("fl_after_beats", 64'(obs_d.size()), 64'd2);
        if (obs_d.size() > 1) begin
            check("fl_after_data", 64'(obs_d[1]), 64'h37363534);
            check("fl_after_words", 64'(obs_w[1]), 64'd4);
        end

        // Asynchronous reset with a beat held at the output and three words packed.
        do_reset(1'b0);
        push_words(7, 8'h51);
        repeat (14) cyc();
        check("ar_pre_valid", 64'(bus.out_valid), 64'd1);
        check("ar_pre_pops", 64'(pop_cnt), 64'd7);
        rd_rst_n = 1'b0;
        #2;
        check("ar_out_valid", 64'(bus.out_valid), 64'd0);
        check("ar_out_data", 64'(bus.out_data), 64'd0);
        check("ar_out_words", 64'(bus.out_words), 64'd0);
        check("ar_flush_done", 64'(bus.flush_done), 64'd0);
        check("ar_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        do_reset(1'b0);
        push_words(4, 8'h41);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && obs_d.size() < 1; c++) cyc();
        check("ar_post_beats", 64'(obs_d.size()), 64'd1);
        if (obs_d.size() > 0) begin
            check("ar_post_data", 64'(obs_d[0]), 64'h44434241);
            check("ar_post_words", 64'(obs_w[0]), 64'd4);
        end

        // Random words, toggling empty flag, random backpressure; scoreboard groups words by four.
        begin
            logic [7:0]  words [64];
            logic [31:0] exp;
            do_reset(1'b0);
            for (int i = 0; i < 64; i++) begin
                words[i] = 8'($urandom);
                fifo_q.push_back(words[i]);
            end
            toggle = 1'b1;
            bus.fifo_empty = 1'b0;
            for (int c = 0; c < 3000 && obs_d.size() < 16; c++) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                cyc();
            end
            check("rnd_beats", 64'(obs_d.size()), 64'd16);
            check("rnd_pops", 64'(pop_cnt), 64'd64);
            for (int b = 0; b < 16 && b < obs_d.size(); b++) begin
                exp = '0;
                for (int k = 0; k < RATIO; k++) exp[k*WIDTH +: WIDTH] = words[b*RATIO + k];
                check($sformatf("rnd_beat%0d_data", b), 64'(obs_d[b]), 64'(exp));
                check($sformatf("rnd_beat%0d_words", b), 64'(obs_w[b]), 64'd4);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_fifo_rd_packer.md
Name: cdc_fifo_rd_packer

Overview:
- Read-domain consumer of the async CDC FIFO.
- Pops WIDTH-bit words from the FIFO read port and packs RATIO consecutive words into one WIDTH*RATIO-bit beat.
- Presents beats on a valid/ready stream to downstream logic.
- A flush request emits any partially filled beat with a word count, so tail data is never stranded.

Parameters:
- WIDTH, 8, FIFO word width in bits.
- RATIO, 4, FIFO words per output beat; legal values are 2 to 16.
- CW, $clog2(RATIO+1), width of the word-count fields.

Ports:
- rd_clk  in  1  read-domain clock; the only clock of this block.
- rd_rst_n  in  1  asynchronous active-low reset.
- fifo_data_out  in  WIDTH  FIFO read data; valid exactly one rd_clk after a cycle with fifo_rd_en=1 and fifo_empty=0.
- fifo_empty  in  1  FIFO empty flag, synchronous to rd_clk.
- fifo_rd_en  out  1  FIFO pop request.
- out_data  out  WIDTH*RATIO  packed beat; first-popped word in bits [WIDTH-1:0].
- out_words  out  CW  number of valid words in out_data, 1..RATIO.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accept.
- flush  in  1  single-cycle pulse; emit partial beat.
- flush_done  out  1  single-cycle pulse when the flush completes.

Behaviour:
- Reset (asynchronous assert, synchronous deassert supplied externally):
  - fifo_rd_en=0, out_valid=0, out_data=0, out_words=0, flush_done=0.
  - pack_cnt=0, inflight=0, state=FILL.
- Internal registers:
  - pack register: RATIO lanes of WIDTH bits.
  - pack_cnt: 0..RATIO.
  - inflight: 0/1, set on the cycle after a read is issued.
  - out register: holds out_data, out_words and out_valid.
- fifo_rd_en is combinational and never asserts while fifo_empty=1.
- Definitions:
  - out_free = !out_valid || out_ready.
  - pending = pack_cnt + inflight.
- fifo_rd_en = state==FILL && !fifo_empty && (pending<RATIO || (pending==RATIO && inflight && pack_cnt==RATIO-1 && out_free)).
  - This gives full throughput: one pop per cycle with out_ready held high.
- Landing word (inflight=1) is written to lane pack_cnt.
  - If this completes the beat (pack_cnt==RATIO-1) and out_free: the full beat, including the landing word, goes to the out register in the same cycle. out_valid=1 and out_words=RATIO on the next cycle. pack_cnt returns to 0.
  - If it completes the beat and !out_free: pack_cnt=RATIO and reads stall, since pending==RATIO with inflight=0.
  - A held full pack transfers on the first cycle out_free=1.
- Out register: holds stable while out_valid && !out_ready. Beat is consumed on out_valid && out_ready.
- State machine:
  - FILL: normal operation. flush=1 goes to DRAIN; no new reads are issued from that cycle on.
  - DRAIN: wait for inflight=0, letting the landing word be packed. Then:
    - pack_cnt==0: go to DONE.
    - pack_cnt>0: go to EMIT.
  - EMIT: when out_free, load out_data from the pack register, with lanes >= pack_cnt forced to 0. Set out_words=pack_cnt, pack_cnt=0, go to DONE.
  - DONE: flush_done=1 for one cycle, return to FILL.
- Flush is ignored outside FILL.
- Flush in the same cycle as a completing landing word: the full beat is handled normally first, then the drain finds pack_cnt=0.
- Reset mid-operation discards pack contents, any in-flight word and any pending out beat. Words popped but not delivered are lost; the system must reset the FIFO together with this block.
- No arithmetic overflow: pack_cnt never exceeds RATIO; out_words is never 0 when out_valid=1.

Test Plan:
1. Reset, then FIFO holds 8 words 0x01..0x08 with WIDTH=8, RATIO=4 and out_ready=1 -> fifo_rd_en high for 8 consecutive cycles. Beats 0x04030201 and then 0x08070605, out_words=4, on consecutive cycles.
2. Same data with out_ready=0 until 10 cycles after the first beat -> exactly 8 pops. First beat held stable while the second stays in the pack register. Both beats are delivered in order after out_ready rises; fifo_rd_en is 0 during the stall.
3. 6 words 0x11..0x16 then FIFO empty, flush pulse -> beat 0x14131211 with words=4, then beat 0x00001615 with words=2, then a one-cycle flush_done.
4. Flush asserted on the cycle a word is in flight (pack_cnt=2) -> the landing word is packed and a partial beat with out_words=3 is emitted. No pop occurs between flush and flush_done.
5. rd_rst_n asserted mid-beat with pack_cnt=3 and out_valid=1 -> all outputs 0 immediately, without waiting for a clock edge. After release, new words pack from lane 0.
6. fifo_empty toggling every cycle -> fifo_rd_en never asserts while empty. Packed data order matches the FIFO pop order over 64 random words, checked by a scoreboard.
